// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b over WIDTH cycles, LSB first,
// with a single registered borrow bit and a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_sr_q, b_sr_q, diff_sr_q;
    logic [CW-1:0]     cnt_q;
    logic              br_q;
    logic              busy_q, done_q, bout_q, ovf_q;
    logic [WIDTH-1:0]  diff_q;

    logic              x, y, d_bit, br_d;
    logic [WIDTH-1:0]  diff_sr_d;

    // One-bit full-subtractor slice on the current LSBs.
    always_comb begin
        x         = a_sr_q[0];
        y         = b_sr_q[0];
        d_bit     = x ^ y ^ br_q;
        br_d      = (~x & y) | (~x & br_q) | (y & br_q);
        diff_sr_d = WIDTH'({d_bit, diff_sr_q} >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            cnt_q     <= '0;
            br_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr_q    <= a;
                        b_sr_q    <= b;
                        br_q      <= 1'b0;
                        diff_sr_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_q    <= a_sr_q >> 1;
                    b_sr_q    <= b_sr_q >> 1;
                    br_q      <= br_d;
                    diff_sr_q <= diff_sr_d;
                    cnt_q     <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // On the last slice x/y are the original operand MSBs.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= diff_sr_d;
                        bout_q  <= br_d;
                        ovf_q   <= (x ^ y) & (x ^ d_bit);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 (directed + random) and WIDTH=13 (random).
module tb_serial_subtractor;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst8 = 1'b1, start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, diff8;
    logic        busy8, done8, bout8, ovf8;
    logic        rst13 = 1'b1, start13 = 1'b0;
    logic [12:0] a13 = '0, b13 = '0, diff13;
    logic        busy13, done13, bout13, ovf13;

    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q13[$];
    exp_t m8, m13;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst(rst13), .start(start13), .a(a13), .b(b13),
        .busy(busy13), .done(done13), .diff(diff13), .bout(bout13), .ovf(ovf13)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t ref_model(input int unsigned w, input logic [31:0] av, input logic [31:0] bv);
        exp_t        r;
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        r.d  = (av - bv) & mask;
        r.bo = (av & mask) < (bv & mask);
        r.ov = (av[w-1] != bv[w-1]) && (r.d[w-1] != av[w-1]);
        return r;
    endfunction

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (busy8 && done8) chk("busy_and_done8", 32'd1, 32'd0);
        if (done8) begin
            if (q8.size() == 0) chk("unexpected_done8", 32'd1, 32'd0);
            else begin
                m8 = q8.pop_front();
                chk("diff8", 32'(diff8), m8.d);
                chk("bout8", 32'(bout8), 32'(m8.bo));
                chk("ovf8",  32'(ovf8),  32'(m8.ov));
            end
        end
    end

    always @(negedge clk) begin
        if (busy13 && done13) chk("busy_and_done13", 32'd1, 32'd0);
        if (done13) begin
            if (q13.size() == 0) chk("unexpected_done13", 32'd1, 32'd0);
            else begin
                m13 = q13.pop_front();
                chk("diff13", 32'(diff13), m13.d);
                chk("bout13", 32'(bout13), 32'(m13.bo));
                chk("ovf13",  32'(ovf13),  32'(m13.ov));
            end
        end
    end

    // poke_at: RUN cycle to assert a stray start; rst_at: RUN cycle to reset;
    // b2b: called at a done cycle, issue without waiting; hold: expected diff mid-RUN (-1 none).
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                       input logic eb, input logic eo, input int poke_at, input int rst_at,
                       input bit b2b, input int hold);
        int   n;
        int   busy_n;
        exp_t e;
        if (!b2b) @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        if (rst_at == 0) begin
            e.d = 32'(ed); e.bo = eb; e.ov = eo;
            q8.push_back(e);
        end
        @(negedge clk);
        start8 = 1'b0;
        n = 1; busy_n = 0;
        while (!done8 && n < 40) begin
            if (busy8) busy_n++;
            if (hold >= 0 && n == 4) chk("hold8", 32'(diff8), 32'(hold));
            if (poke_at != 0 && n == poke_at) begin
                a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
            end
            if (poke_at != 0 && n == poke_at + 1) start8 = 1'b0;
            if (rst_at != 0 && n == rst_at) rst8 = 1'b1;
            @(negedge clk);
            n++;
            if (rst_at != 0 && n == rst_at + 1) begin
                rst8 = 1'b0;
                chk("abort_busy8", 32'(busy8), 32'd0);
                chk("abort_done8", 32'(done8), 32'd0);
                chk("abort_diff8", 32'(diff8), 32'd0);
                chk("abort_bout8", 32'(bout8), 32'd0);
                chk("abort_ovf8",  32'(ovf8),  32'd0);
                repeat (12) @(negedge clk);
                return;
            end
        end
        chk("latency8", 32'(n), 32'd9);
        chk("busy_cycles8", 32'(busy_n), 32'd8);
    endtask

    task automatic op13(input logic [12:0] av, input logic [12:0] bv);
        int n;
        @(negedge clk);
        a13 = av; b13 = bv; start13 = 1'b1;
        q13.push_back(ref_model(13, 32'(av), 32'(bv)));
        @(negedge clk);
        start13 = 1'b0;
        n = 1;
        while (!done13 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency13", 32'(n), 32'd14);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        exp_t        r;
        logic [7:0]  ra, rb;
        logic [12:0] sa, sb;

        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst13 = 1'b0;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_diff8", 32'(diff8), 32'd0);
        chk("rst_bout8", 32'(bout8), 32'd0);
        chk("rst_ovf8",  32'(ovf8),  32'd0);
        chk("rst_busy13", 32'(busy13), 32'd0);

        // Reset and start on the same edge: reset wins.
        rst8 = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        chk("rst_wins_busy8", 32'(busy8), 32'd0);
        rst8 = 1'b0; start8 = 1'b0;
        @(negedge clk);
        chk("rst_wins_idle8", 32'(busy8), 32'd0);

        op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 0, 1'b0, -1);
        op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0, 0, 1'b0, -1);
        op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 0, 1'b0, -1);
        op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0, 0, 1'b0, -1);
        op8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0, -1);
        op8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 0, 0, 1'b0, -1);
        op8(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 0, 0, 1'b0, -1);

        // Stray start during RUN must be ignored.
        op8(8'h20, 8'h11, 8'h0F, 1'b0, 1'b0, 3, 0, 1'b0, -1);
        repeat (2) @(negedge clk);

        // Back-to-back: start held during DONE; prior result holds through RUN.
        op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 0, 1'b0, -1);
        op8(8'd10, 8'd4, 8'h06, 1'b0, 1'b0, 0, 0, 1'b1, 32'h7F);
        chk("b2b_diff_now8", 32'(diff8), 32'h06);

        // Reset at RUN cycle 4 aborts without a done pulse.
        op8(8'h40, 8'h01, 8'h00, 1'b0, 1'b0, 0, 4, 1'b0, -1);
        op8(8'h09, 8'h0C, 8'hFD, 1'b1, 1'b0, 0, 0, 1'b0, -1);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            r  = ref_model(8, 32'(ra), 32'(rb));
            op8(ra, rb, r.d[7:0], r.bo, r.ov, 0, 0, 1'b0, -1);
        end
        for (int i = 0; i < 1000; i++) begin
            sa = 13'($urandom);
            sb = 13'($urandom);
            op13(sa, sb);
        end

        repeat (4) @(negedge clk);
        chk("q8_drained",  32'(q8.size()),  32'd0);
        chk("q13_drained", 32'(q13.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
